// File: rtl/edge_pulse_pkg.sv
// Shared constants and helpers for the multi-channel edge-to-pulse converter.
package edge_pulse_pkg;

  // Per-channel edge selection encodings (EdgeMode field values).
  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/edge_pulse_ch.sv
// One converter channel: optional synchronizer, history flop, edge detect,
// pulse engine with retrigger policy, sticky flag and saturating counter.
module edge_pulse_ch
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int RETRIGGER   = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_sig,
  input  logic [1:0]       edge_mode,
  input  logic             flag_clear,
  input  logic             count_clear,
  output logic             out_pulse,
  output logic             event_flag,
  output logic [CNT_W-1:0] edge_count
);

  // Remaining-cycles counter needs at least one bit even for single-cycle pulses.
  localparam int                REM_W   = (clog2(PULSE_LEN) < 1) ? 1 : clog2(PULSE_LEN);
  localparam logic [REM_W-1:0]  RELOAD  = REM_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic             sampled;
  logic             history;
  logic             rise;
  logic             fall;
  logic             want_rise;
  logic             want_fall;
  logic             detect;
  logic [REM_W-1:0] remain;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      // Input is already in the Clock domain: sample it directly.
      assign sampled = in_sig;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Shift chain; bit 0 is the first (metastability-exposed) stage.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q <= (sync_q << 1) | SYNC_STAGES'(in_sig);
        end
      end

      assign sampled = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // History resets low, so a line already high at reset release reads as a rising edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      history <= 1'b0;
    end else begin
      history <= sampled;
    end
  end

  assign rise      = sampled & ~history;
  assign fall      = ~sampled & history;
  assign want_rise = (edge_mode == EDGE_RISE) || (edge_mode == EDGE_BOTH);
  assign want_fall = (edge_mode == EDGE_FALL) || (edge_mode == EDGE_BOTH);
  assign detect    = (want_rise & rise) | (want_fall & fall);

  // Pulse engine: start on detect when idle, count down while active,
  // chain straight into a new pulse if an edge lands on the last cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_pulse <= 1'b0;
      remain    <= '0;
    end else if (!out_pulse) begin
      if (detect) begin
        out_pulse <= 1'b1;
        remain    <= RELOAD;
      end
    end else if (remain != '0) begin
      if (detect && (RETRIGGER != 0)) begin
        remain <= RELOAD;
      end else begin
        remain <= remain - REM_W'(1);
      end
    end else begin
      if (detect) begin
        remain <= RELOAD;
      end else begin
        out_pulse <= 1'b0;
      end
    end
  end

  // Sticky flag: a new edge wins over a coincident clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      event_flag <= 1'b0;
    end else if (detect) begin
      event_flag <= 1'b1;
    end else if (flag_clear) begin
      event_flag <= 1'b0;
    end
  end

  // Saturating edge counter; a clear with a coincident edge restarts at one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      edge_count <= '0;
    end else if (count_clear) begin
      edge_count <= detect ? CNT_W'(1) : '0;
    end else if (detect && (edge_count != CNT_MAX)) begin
      edge_count <= edge_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multi_edge_pulse.sv
// Multi-channel edge-to-pulse converter: replicates one channel per input
// line and packs the per-channel results onto flat buses.
module multi_edge_pulse
  import edge_pulse_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 1,
  parameter int RETRIGGER   = 0,
  parameter int CNT_W       = 8
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [CHANNELS-1:0]       InSig,
  input  logic [2*CHANNELS-1:0]     EdgeMode,
  input  logic [CHANNELS-1:0]       FlagClear,
  input  logic                      CountClear,
  output logic [CHANNELS-1:0]       OutPulse,
  output logic [CHANNELS-1:0]       EventFlag,
  output logic [CHANNELS*CNT_W-1:0] EdgeCount
);

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      edge_pulse_ch #(
        .SYNC_STAGES (SYNC_STAGES),
        .PULSE_LEN   (PULSE_LEN),
        .RETRIGGER   (RETRIGGER),
        .CNT_W       (CNT_W)
      ) u_ch (
        .clock       (Clock),
        .reset       (Reset),
        .in_sig      (InSig[i]),
        .edge_mode   (EdgeMode[2*i +: 2]),
        .flag_clear  (FlagClear[i]),
        .count_clear (CountClear),
        .out_pulse   (OutPulse[i]),
        .event_flag  (EventFlag[i]),
        .edge_count  (EdgeCount[CNT_W*i +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_edge_pulse.sv
// Directed bench for multi_edge_pulse: three configurations driven side by side.
module tb_multi_edge_pulse;

  logic        Clock;
  logic        Reset;

  // Config A: no synchronizer, single-cycle pulses, 2-bit counters.
  logic [3:0]  in_a;
  logic [7:0]  mode_a;
  logic [3:0]  fc_a;
  logic        cc_a;
  logic [3:0]  out_a;
  logic [3:0]  flag_a;
  logic [7:0]  cnt_a;

  // Configs B and C share stimulus: 2-stage sync, 4-cycle pulses; C retriggers.
  logic [3:0]  in_b;
  logic [7:0]  mode_b;
  logic [3:0]  fc_b;
  logic        cc_b;
  logic [3:0]  out_b;
  logic [3:0]  flag_b;
  logic [31:0] cnt_b;
  logic [3:0]  out_c;
  logic [3:0]  flag_c;
  logic [31:0] cnt_c;

  int checks;
  int failures;

  multi_edge_pulse #(
    .CHANNELS(4), .SYNC_STAGES(0), .PULSE_LEN(1), .RETRIGGER(0), .CNT_W(2)
  ) u_a (
    .Clock(Clock), .Reset(Reset), .InSig(in_a), .EdgeMode(mode_a),
    .FlagClear(fc_a), .CountClear(cc_a),
    .OutPulse(out_a), .EventFlag(flag_a), .EdgeCount(cnt_a)
  );

  multi_edge_pulse #(
    .CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(4), .RETRIGGER(0), .CNT_W(8)
  ) u_b (
    .Clock(Clock), .Reset(Reset), .InSig(in_b), .EdgeMode(mode_b),
    .FlagClear(fc_b), .CountClear(cc_b),
    .OutPulse(out_b), .EventFlag(flag_b), .EdgeCount(cnt_b)
  );

  multi_edge_pulse #(
    .CHANNELS(4), .SYNC_STAGES(2), .PULSE_LEN(4), .RETRIGGER(1), .CNT_W(8)
  ) u_c (
    .Clock(Clock), .Reset(Reset), .InSig(in_b), .EdgeMode(mode_b),
    .FlagClear(fc_b), .CountClear(cc_b),
    .OutPulse(out_c), .EventFlag(flag_c), .EdgeCount(cnt_c)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [6:0] seq_rel;
    logic [9:0] seq_b;
    logic [9:0] seq_c;

    checks   = 0;
    failures = 0;

    Reset  = 1'b1;
    in_a   = 4'b0000;
    mode_a = 8'b01_11_00_01;   // ch3 rise, ch2 both, ch1 off, ch0 rise
    fc_a   = 4'b0000;
    cc_a   = 1'b0;
    in_b   = 4'b0001;          // ch0 held high through reset
    mode_b = 8'b00_00_11_01;   // ch1 both, ch0 rise
    fc_b   = 4'b0000;
    cc_b   = 1'b0;

    // Reset state
    #1;
    check("rst_out_a", out_a, 0);
    check("rst_cnt_a", cnt_a, 0);
    check("rst_flag_a", flag_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_cnt_b", cnt_b, 0);
    tick();
    tick();
    check("rst_hold_out_b", out_b, 0);
    Reset = 1'b0;

    // Input high at release: one 4-cycle pulse starting after the 3rd edge
    seq_rel = 7'b0111100;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("rel_pulse_b_%0d", i), out_b[0], seq_rel[i]);
      check($sformatf("rel_pulse_c_%0d", i), out_c[0], seq_rel[i]);
    end
    check("rel_cnt_b", cnt_b[7:0], 1);
    check("rel_flag_b", flag_b[0], 1);

    // Config A rise: pulse on the sampling edge only, falling edge ignored
    in_a[0] = 1'b1;
    tick();
    check("a_rise_pulse", out_a[0], 1);
    check("a_rise_cnt", cnt_a[1:0], 1);
    check("a_rise_flag", flag_a[0], 1);
    tick();
    check("a_rise_end", out_a[0], 0);
    in_a[0] = 1'b0;
    tick();
    check("a_fall_ignored", out_a[0], 0);
    check("a_fall_cnt", cnt_a[1:0], 1);

    // Fall mode; the mode change itself is not an edge
    mode_a[1:0] = 2'b10;
    tick();
    check("a_modechg_none", out_a[0], 0);
    in_a[0] = 1'b1;
    tick();
    check("a_fallmode_rise", out_a[0], 0);
    in_a[0] = 1'b0;
    tick();
    check("a_fallmode_fall", out_a[0], 1);
    check("a_fallmode_cnt", cnt_a[1:0], 2);

    // Counter clear, saturation at 3, clear with coincident edge
    mode_a[1:0] = 2'b01;
    cc_a = 1'b1;
    tick();
    check("a_cnt_clear", cnt_a[1:0], 0);
    cc_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_a[0] = 1'b1;
      tick();
      in_a[0] = 1'b0;
      tick();
    end
    check("a_cnt_sat", cnt_a[1:0], 3);
    in_a[0] = 1'b1;
    cc_a    = 1'b1;
    tick();
    check("a_cnt_clear_edge", cnt_a[1:0], 1);
    check("a_cnt_clear_pulse", out_a[0], 1);
    cc_a    = 1'b0;
    in_a[0] = 1'b0;
    tick();

    // Flag set wins over clear; clear alone drops it; neighbour untouched
    in_a[3] = 1'b1;
    tick();
    check("a_flag3_set", flag_a[3], 1);
    in_a[2] = 1'b1;
    fc_a[2] = 1'b1;
    tick();
    check("a_flag2_setclr", flag_a[2], 1);
    check("a_pulse2", out_a[2], 1);
    tick();
    check("a_flag2_clr", flag_a[2], 0);
    check("a_flag3_keep", flag_a[3], 1);
    fc_a[2] = 1'b0;

    // Mode off: no pulse, flag or count
    in_a[1] = 1'b1;
    tick();
    check("a_off_pulse", out_a[1], 0);
    check("a_off_flag", flag_a[1], 0);
    check("a_off_cnt", cnt_a[3:2], 0);

    // Toggle ch1 twice two cycles apart: B holds 4 cycles, C extends to 6
    seq_b = 10'b0000111100;
    seq_c = 10'b0011111100;
    in_b[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) in_b[1] = 1'b0;
      tick();
      check($sformatf("b_retrig0_%0d", i), out_b[1], seq_b[i]);
      check($sformatf("c_retrig1_%0d", i), out_c[1], seq_c[i]);
    end
    check("b_ch1_cnt", cnt_b[15:8], 2);
    check("c_ch1_cnt", cnt_c[15:8], 2);
    check("c_ch1_flag", flag_c[1], 1);

    // Reset mid-pulse: outputs drop at once, nothing after release with static input
    mode_b[1:0] = 2'b10;
    in_b[0] = 1'b0;
    tick();
    tick();
    tick();
    tick();
    check("b_mid_pulse", out_b[0], 1);
    #2;
    Reset = 1'b1;
    #1;
    check("mid_rst_out_b", out_b, 0);
    check("mid_rst_out_c", out_c, 0);
    check("mid_rst_cnt_b", cnt_b, 0);
    check("mid_rst_flag_b", flag_b, 0);
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("post_rst_b_%0d", i), out_b, 0);
      check($sformatf("post_rst_c_%0d", i), out_c, 0);
    end
    check("post_rst_cnt_b", cnt_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
